hazard_stall_controller: RTL and testbench
==========================================

# hazard_stall_controller

Sequential hazard and stall controller for the 5-stage MIPS pipeline. It covers the cases that operand forwarding cannot resolve: load-use stalls in ID, taken-branch flushes, and pipeline freeze while data memory is busy, with a per-episode memory timeout. It also handles a syscall halt. It drives the PC and pipeline-register enables and flushes, and keeps saturating performance counters.

## Interface
- CNT_W, 16, width of each performance counter
- MEM_TIMEOUT, 255, maximum consecutive memory-wait cycles before error (≥2)

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- id_op  in  6  opcode of ID-stage instruction
- id_func  in  6  funct of ID-stage instruction
- id_r1  in  5  rs of ID-stage instruction
- id_r2  in  5  rt of ID-stage instruction
- ex_waddr  in  5  destination register of EX-stage instruction
- ex_rw  in  1  EX-stage instruction writes a register
- ex_mtr  in  1  EX-stage instruction is a load
- ex_branch_taken  in  1  EX resolved a taken branch or jump
- mem_req  in  1  MEM-stage instruction accesses data memory
- mem_ready  in  1  data memory completes the access this cycle
- wb_syscall  in  1  WB-stage instruction is SYSCALL
- pc_en  out  1  PC update enable
- ifid_en  out  1  IF/ID register enable
- ifid_flush  out  1  IF/ID loads a bubble
- idex_en  out  1  ID/EX register enable
- idex_flush  out  1  ID/EX loads a bubble
- exmem_en  out  1  EX/MEM register enable
- memwb_flush  out  1  MEM/WB loads a bubble
- halted  out  1  state is HALT or ERROR
- mem_timeout  out  1  state is ERROR
- stall_cnt  out  CNT_W  load-use stall cycles
- flush_cnt  out  CNT_W  branch flush events
- wait_cnt  out  CNT_W  memory freeze cycles

## Operation
- Register-use decode (ID):
  - r1_used is 1 except for J(02), JAL(03), LUI(0F), and R-type func SLL(00)/SRL(02)/SRA(03)/SYSCALL(0C).
  - r2_used is 1 for R-type (op 00) except JR(08)/SYSCALL(0C), and for BEQ(04), BNE(05), SW(2B).
- load_use = ex_rw & ex_mtr & ex_waddr≠0 & ((r1_used & ex_waddr==id_r1) | (r2_used & ex_waddr==id_r2)).
- freeze = mem_req & !mem_ready.
- States:
  - RUN: normal operation.
  - MWAIT: one or more consecutive freeze cycles have elapsed.
  - HALT: entered on syscall.
  - ERROR: entered on memory timeout.
- Outputs in RUN/MWAIT use this priority; a higher condition masks the lower ones:
  1. freeze: pc_en=ifid_en=idex_en=exmem_en=0; memwb_flush=1; ifid_flush=idex_flush=0.
  2. ex_branch_taken: all enables 1; ifid_flush=idex_flush=1.
  3. load_use: pc_en=ifid_en=0; idex_flush=1; idex_en=exmem_en=1.
  4. otherwise: all enables 1, all flushes 0.
- HALT/ERROR: pc_en=ifid_en=idex_en=exmem_en=0; ifid_flush=0; idex_flush=memwb_flush=1. These hold until reset.
- Transitions, evaluated at each edge, first match wins:
  1. wb_syscall → HALT, from RUN or MWAIT.
  2. In MWAIT with freeze and ep==MEM_TIMEOUT-1 → ERROR.
  3. freeze → MWAIT.
  4. !freeze → RUN.
- ep (episode counter, width ≥ clog2(MEM_TIMEOUT)):
  - cleared on entry to RUN;
  - set to 1 on RUN→MWAIT;
  - incremented on each edge while it stays in MWAIT.
- Counters:
  - Each increments by 1 per edge in which its condition is the active output case in RUN/MWAIT: stall_cnt for load_use, flush_cnt for branch, wait_cnt for freeze.
  - Each saturates at 2^CNT_W−1.
  - None counts in HALT/ERROR.
- Counters and mem_timeout are only cleared by reset.

## Timing
- Stall, flush and freeze outputs are combinational from the inputs and current state, with zero latency.
- State, ep and counters are registered.
- With rst_n=0 at an edge:
  - state becomes RUN, ep=0, counters=0.
  - While rst_n is low, outputs are forced: pc_en=ifid_en=idex_en=exmem_en=0, ifid_flush=idex_flush=memwb_flush=1, halted=0, mem_timeout=0.
- A load-use stall lasts exactly 1 cycle: the load advances to MEM next cycle and load_use deasserts.
- Memory handshake: MEM holds mem_req until mem_ready. A freeze that lasts N cycles, with N ≤ MEM_TIMEOUT−1, is followed by normal flow on the cycle mem_ready=1.
- Timeout: if mem_ready stays 0 for MEM_TIMEOUT consecutive cycles, state is ERROR on the following cycle.
- mem_ready=1 on the same cycle that ep==MEM_TIMEOUT-1 gives no error.
- Reset asserted mid-freeze or in HALT/ERROR returns to RUN on the next edge.

## Test plan
- ID=ADD r3,r2,r4 (op 00, func 20); EX=LW r2 → pc_en=0, ifid_en=0, idex_flush=1 for 1 cycle; stall_cnt=1. Repeat with ex_waddr=0 → no stall.
- LUI r5 in ID with EX=LW r5 (r1 unused; LUI rt=r5 is the destination, not a source) → no stall. SW r5 in ID with EX=LW r5 via id_r2 → stall.
- ex_branch_taken=1 while load_use=1 → ifid_flush=idex_flush=1, pc_en=1; flush_cnt+1, stall_cnt unchanged.
- mem_req=1, mem_ready=0 for 5 cycles, then 1 → 5 freeze cycles (exmem_en=0, memwb_flush=1); wait_cnt=5; RUN after.
- MEM_TIMEOUT=4, mem_ready held 0 → after 4 freeze cycles state is ERROR: halted=1, mem_timeout=1; stays until rst_n=0 for one edge.
- wb_syscall=1 during a branch flush → HALT next cycle: pc_en=0, halted=1; counters frozen. CNT_W=2 with 5 load-use stalls → stall_cnt=3.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// Hazard and stall controller for the 5-stage MIPS pipeline: load-use stalls,
// taken-branch flushes, memory-wait freeze with timeout, syscall halt, perf counters.
module hazard_stall_controller #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       id_op,
    input  logic [5:0]       id_func,
    input  logic [4:0]       id_r1,
    input  logic [4:0]       id_r2,
    input  logic [4:0]       ex_waddr,
    input  logic             ex_rw,
    input  logic             ex_mtr,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             wb_syscall,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_flush,
    output logic             halted,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt
);

    localparam int EP_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [EP_W-1:0] EP_LAST = EP_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MWAIT,
        ST_HALT,
        ST_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [EP_W-1:0]   ep_q, ep_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              r1_used, r2_used, load_use, freeze, active;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        r1_used = 1'b1;
        r2_used = 1'b0;
        case (id_op)
            6'h02, 6'h03, 6'h0F: r1_used = 1'b0;
            6'h00: begin
                r2_used = !(id_func == 6'h08 || id_func == 6'h0C);
                if (id_func == 6'h00 || id_func == 6'h02 || id_func == 6'h03 || id_func == 6'h0C)
                    r1_used = 1'b0;
            end
            6'h04, 6'h05, 6'h2B: r2_used = 1'b1;
            default: ;
        endcase
    end

    assign load_use = ex_rw & ex_mtr & (ex_waddr != 5'd0) &
                      ((r1_used & (ex_waddr == id_r1)) | (r2_used & (ex_waddr == id_r2)));
    assign freeze   = mem_req & ~mem_ready;
    assign active   = (state_q == ST_RUN) || (state_q == ST_MWAIT);

    // Counters only credit the condition that actually drives the outputs this cycle.
    always_comb begin
        state_d     = state_q;
        ep_d        = ep_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        if (active) begin
            if (freeze)               wait_cnt_d  = sat_inc(wait_cnt_q);
            else if (ex_branch_taken) flush_cnt_d = sat_inc(flush_cnt_q);
            else if (load_use)        stall_cnt_d = sat_inc(stall_cnt_q);

            if (wb_syscall)
                state_d = ST_HALT;
            else if (state_q == ST_MWAIT && freeze && ep_q == EP_LAST)
                state_d = ST_ERROR;
            else if (freeze)
                state_d = ST_MWAIT;
            else
                state_d = ST_RUN;

            if (state_d == ST_MWAIT)
                ep_d = (state_q == ST_MWAIT) ? ep_q + EP_W'(1) : EP_W'(1);
            else
                ep_d = '0;
        end
    end

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_flush  = 1'b0;
        exmem_en    = 1'b1;
        memwb_flush = 1'b0;
        if (!rst_n || !active) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = !rst_n;
            idex_en     = 1'b0;
            idex_flush  = 1'b1;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (freeze) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_flush  = 1'b1;
        end
    end

    assign halted      = rst_n & !active;
    assign mem_timeout = rst_n & (state_q == ST_ERROR);
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;
    assign wait_cnt    = wait_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            ep_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            ep_q        <= ep_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: two instances (default sizes, and CNT_W=2 / MEM_TIMEOUT=4)
// share directed stimulus and are checked every cycle against a rule-level model.
module tb_hazard_stall_controller;

    logic clk = 1'b0;
    logic rst_n;
    logic [5:0] id_op, id_func;
    logic [4:0] id_r1, id_r2, ex_waddr;
    logic ex_rw, ex_mtr, ex_branch_taken, mem_req, mem_ready, wb_syscall;

    logic a_pc_en, a_ifid_en, a_ifid_flush, a_idex_en, a_idex_flush, a_exmem_en, a_memwb_flush;
    logic a_halted, a_mem_timeout;
    logic [15:0] a_stall, a_flush, a_wait;
    logic b_pc_en, b_ifid_en, b_ifid_flush, b_idex_en, b_idex_flush, b_exmem_en, b_memwb_flush;
    logic b_halted, b_mem_timeout;
    logic [1:0] b_stall, b_flush, b_wait;

    int nvec = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    hazard_stall_controller #(.CNT_W(16), .MEM_TIMEOUT(255)) dut_a (
        .clk(clk), .rst_n(rst_n), .id_op(id_op), .id_func(id_func), .id_r1(id_r1), .id_r2(id_r2),
        .ex_waddr(ex_waddr), .ex_rw(ex_rw), .ex_mtr(ex_mtr), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .wb_syscall(wb_syscall),
        .pc_en(a_pc_en), .ifid_en(a_ifid_en), .ifid_flush(a_ifid_flush), .idex_en(a_idex_en),
        .idex_flush(a_idex_flush), .exmem_en(a_exmem_en), .memwb_flush(a_memwb_flush),
        .halted(a_halted), .mem_timeout(a_mem_timeout),
        .stall_cnt(a_stall), .flush_cnt(a_flush), .wait_cnt(a_wait)
    );

    hazard_stall_controller #(.CNT_W(2), .MEM_TIMEOUT(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_op(id_op), .id_func(id_func), .id_r1(id_r1), .id_r2(id_r2),
        .ex_waddr(ex_waddr), .ex_rw(ex_rw), .ex_mtr(ex_mtr), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .wb_syscall(wb_syscall),
        .pc_en(b_pc_en), .ifid_en(b_ifid_en), .ifid_flush(b_ifid_flush), .idex_en(b_idex_en),
        .idex_flush(b_idex_flush), .exmem_en(b_exmem_en), .memwb_flush(b_memwb_flush),
        .halted(b_halted), .mem_timeout(b_mem_timeout),
        .stall_cnt(b_stall), .flush_cnt(b_flush), .wait_cnt(b_wait)
    );

    logic [8:0]  ctl_o   [2];
    logic [15:0] stall_o [2];
    logic [15:0] flush_o [2];
    logic [15:0] wait_o  [2];
    assign ctl_o[0] = {a_pc_en, a_ifid_en, a_ifid_flush, a_idex_en, a_idex_flush, a_exmem_en,
                       a_memwb_flush, a_halted, a_mem_timeout};
    assign ctl_o[1] = {b_pc_en, b_ifid_en, b_ifid_flush, b_idex_en, b_idex_flush, b_exmem_en,
                       b_memwb_flush, b_halted, b_mem_timeout};
    assign stall_o[0] = a_stall;
    assign flush_o[0] = a_flush;
    assign wait_o[0]  = a_wait;
    assign stall_o[1] = {14'd0, b_stall};
    assign flush_o[1] = {14'd0, b_flush};
    assign wait_o[1]  = {14'd0, b_wait};

    // Model: stopped flags, length of the current run of freeze cycles, and counter values.
    typedef struct {
        bit halt;
        bit err;
        int frz;
        int stall;
        int flush;
        int waitc;
    } model_t;
    model_t m [2];

    function automatic int mt_of(input int i);
        return (i == 0) ? 255 : 4;
    endfunction

    function automatic int cmax_of(input int i);
        return (i == 0) ? 65535 : 3;
    endfunction

    function automatic bit rs_used(input logic [5:0] op, input logic [5:0] fn);
        return !(op inside {6'h02, 6'h03, 6'h0F} || (op == 6'h00 && fn inside {6'h00, 6'h02, 6'h03, 6'h0C}));
    endfunction

    function automatic bit rt_used(input logic [5:0] op, input logic [5:0] fn);
        return (op == 6'h00 && !(fn inside {6'h08, 6'h0C})) || (op inside {6'h04, 6'h05, 6'h2B});
    endfunction

    function automatic bit lu_now();
        if (!(ex_rw && ex_mtr) || ex_waddr == 5'd0) return 1'b0;
        return (rs_used(id_op, id_func) && ex_waddr == id_r1) ||
               (rt_used(id_op, id_func) && ex_waddr == id_r2);
    endfunction

    function automatic model_t step(input model_t s, input int mt, input int cmax);
        model_t n;
        bit frz;
        n = s;
        if (!rst_n) begin
            n.halt = 0; n.err = 0; n.frz = 0; n.stall = 0; n.flush = 0; n.waitc = 0;
            return n;
        end
        if (s.halt || s.err) return s;
        frz = mem_req && !mem_ready;
        if (frz)                  n.waitc = (s.waitc < cmax) ? s.waitc + 1 : s.waitc;
        else if (ex_branch_taken) n.flush = (s.flush < cmax) ? s.flush + 1 : s.flush;
        else if (lu_now())        n.stall = (s.stall < cmax) ? s.stall + 1 : s.stall;
        n.frz = frz ? s.frz + 1 : 0;
        if (wb_syscall)            n.halt = 1;
        else if (frz && n.frz >= mt) n.err = 1;
        return n;
    endfunction

    // Bit order: pc_en ifid_en ifid_flush idex_en idex_flush exmem_en memwb_flush halted mem_timeout
    function automatic logic [8:0] exp_ctl(input model_t s);
        if (!rst_n)                   return 9'b001010100;
        if (s.halt || s.err)          return {8'b00001011, s.err};
        if (mem_req && !mem_ready)    return 9'b000000100;
        if (ex_branch_taken)          return 9'b111111000;
        if (lu_now())                 return 9'b000111000;
        return 9'b110101000;
    endfunction

    task automatic check(input string nm, input int got, input int exp);
        nvec++;
        if (got != exp) begin
            nfail++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", nm, $time, got, exp);
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) m[i] <= step(m[i], mt_of(i), cmax_of(i));
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check($sformatf("ctl[%0d]", i), int'(ctl_o[i]), int'(exp_ctl(m[i])));
            check($sformatf("stall_cnt[%0d]", i), int'(stall_o[i]), m[i].stall);
            check($sformatf("flush_cnt[%0d]", i), int'(flush_o[i]), m[i].flush);
            check($sformatf("wait_cnt[%0d]", i), int'(wait_o[i]), m[i].waitc);
        end
    end

    logic [5:0] tab_op [14] = '{6'h02, 6'h03, 6'h0F, 6'h00, 6'h00, 6'h00, 6'h00,
                                6'h00, 6'h00, 6'h04, 6'h05, 6'h2B, 6'h23, 6'h08};
    logic [5:0] tab_fn [14] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h0C,
                                6'h08, 6'h20, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    bit tab_rs [14] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
    bit tab_rt [14] = '{0, 0, 0, 1, 1, 1, 0, 0, 1, 1, 1, 1, 0, 0};

    task automatic idle();
        id_op = 6'h08; id_func = 6'h00; id_r1 = 5'd0; id_r2 = 5'd0;
        ex_waddr = 5'd0; ex_rw = 1'b0; ex_mtr = 1'b0; ex_branch_taken = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0; wb_syscall = 1'b0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic set_id(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] r1, input logic [4:0] r2);
        id_op = op; id_func = fn; id_r1 = r1; id_r2 = r2;
    endtask

    task automatic set_lw(input logic [4:0] wa);
        ex_waddr = wa; ex_rw = 1'b1; ex_mtr = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        idle();
        settle();
        check("rst_pc_en", int'(a_pc_en), 0);
        check("rst_idex_flush", int'(a_idex_flush), 1);
        check("rst_halted", int'(b_halted), 0);
        check("rst_stall_cnt", int'(a_stall), 0);

        nxt(); rst_n = 1'b1; settle();
        check("run_pc_en", int'(a_pc_en), 1);
        check("run_ifid_flush", int'(a_ifid_flush), 0);

        // ADD r3,r2,r4 behind LW r2
        nxt(); set_id(6'h00, 6'h20, 5'd2, 5'd4); set_lw(5'd2); settle();
        check("lu_pc_en", int'(a_pc_en), 0);
        check("lu_ifid_en", int'(a_ifid_en), 0);
        check("lu_idex_flush", int'(a_idex_flush), 1);
        check("lu_idex_en", int'(a_idex_en), 1);
        nxt(); settle();
        check("lu_stall_cnt", int'(a_stall), 1);
        check("lu_release_pc_en", int'(a_pc_en), 1);

        nxt(); set_id(6'h00, 6'h20, 5'd0, 5'd4); set_lw(5'd0); settle();
        check("r0_no_stall", int'(a_pc_en), 1);
        nxt(); set_id(6'h0F, 6'h00, 5'd5, 5'd5); set_lw(5'd5); settle();
        check("lui_no_stall", int'(a_pc_en), 1);
        nxt(); set_id(6'h2B, 6'h00, 5'd1, 5'd5); set_lw(5'd5); settle();
        check("sw_rt_stall", int'(a_pc_en), 0);
        check("sw_rt_idex_flush", int'(a_idex_flush), 1);
        nxt(); settle();
        check("sw_stall_cnt", int'(a_stall), 2);

        // taken branch masks a load-use
        nxt(); set_id(6'h00, 6'h20, 5'd2, 5'd4); set_lw(5'd2); ex_branch_taken = 1'b1; settle();
        check("br_ifid_flush", int'(a_ifid_flush), 1);
        check("br_idex_flush", int'(a_idex_flush), 1);
        check("br_pc_en", int'(a_pc_en), 1);
        nxt(); settle();
        check("br_flush_cnt", int'(a_flush), 1);
        check("br_stall_cnt", int'(a_stall), 2);

        // 5-cycle freeze: normal for A, timeout for B (MEM_TIMEOUT=4)
        for (int k = 1; k <= 5; k++) begin
            nxt(); mem_req = 1'b1; mem_ready = 1'b0; settle();
            check("frz_exmem_en", int'(a_exmem_en), 0);
            check("frz_memwb_flush", int'(a_memwb_flush), 1);
            if (k == 4) check("b_pre_timeout", int'(b_mem_timeout), 0);
            if (k == 5) check("b_timeout", int'(b_mem_timeout), 1);
        end
        nxt(); mem_req = 1'b1; mem_ready = 1'b1; settle();
        check("ready_pc_en", int'(a_pc_en), 1);
        check("ready_exmem_en", int'(a_exmem_en), 1);
        check("a_wait_cnt5", int'(a_wait), 5);
        check("b_err_halted", int'(b_halted), 1);
        nxt(); settle();
        check("a_back_run", int'(a_halted), 0);
        check("b_err_sticky", int'(b_mem_timeout), 1);
        check("b_wait_sat", int'(b_wait), 3);

        nxt(); rst_n = 1'b0; settle();
        check("rst_forces_halted", int'(b_halted), 0);
        check("rst_forces_timeout", int'(b_mem_timeout), 0);
        nxt(); rst_n = 1'b1; settle();
        check("rst_clears_err", int'(b_halted), 0);
        check("rst_clears_wait", int'(a_wait), 0);

        // B: ready arrives on the last allowed cycle
        for (int k = 0; k < 3; k++) begin
            nxt(); mem_req = 1'b1; mem_ready = 1'b0; settle();
        end
        nxt(); mem_req = 1'b1; mem_ready = 1'b1; settle();
        check("b_edge_ready_pc_en", int'(b_pc_en), 1);
        nxt(); settle();
        check("b_edge_no_err", int'(b_halted), 0);
        check("b_edge_wait", int'(b_wait), 3);

        for (int k = 0; k < 5; k++) begin
            nxt(); set_id(6'h00, 6'h20, 5'd2, 5'd4); set_lw(5'd2); settle();
        end
        nxt(); settle();
        check("b_stall_sat", int'(b_stall), 3);
        check("a_stall5", int'(a_stall), 5);

        // Register-use decode: hazard through rs only, then through rt only
        for (int t = 0; t < 14; t++) begin
            for (int s = 0; s < 2; s++) begin
                nxt();
                set_id(tab_op[t], tab_fn[t], (s == 0) ? 5'd7 : 5'd0, (s == 0) ? 5'd0 : 5'd7);
                set_lw(5'd7);
                settle();
                check($sformatf("decode[%0d].%s", t, (s == 0) ? "rs" : "rt"), int'(a_pc_en),
                      ((s == 0) ? tab_rs[t] : tab_rt[t]) ? 0 : 1);
            end
        end

        // syscall during a branch flush
        nxt(); rst_n = 1'b0; settle();
        nxt(); rst_n = 1'b1; settle();
        nxt(); ex_branch_taken = 1'b1; wb_syscall = 1'b1; settle();
        check("sys_ifid_flush", int'(a_ifid_flush), 1);
        check("sys_pc_en", int'(a_pc_en), 1);
        nxt(); settle();
        check("halt_halted", int'(a_halted), 1);
        check("halt_pc_en", int'(a_pc_en), 0);
        check("halt_no_timeout", int'(a_mem_timeout), 0);
        check("halt_flush_cnt", int'(a_flush), 1);
        nxt(); set_id(6'h00, 6'h20, 5'd2, 5'd4); set_lw(5'd2); ex_branch_taken = 1'b1; settle();
        nxt(); mem_req = 1'b1; mem_ready = 1'b0; settle();
        nxt(); settle();
        check("halt_stall_frozen", int'(a_stall), 0);
        check("halt_flush_frozen", int'(a_flush), 1);
        check("halt_wait_frozen", int'(a_wait), 0);
        check("halt_sticky", int'(a_halted), 1);

        // reset asserted in the middle of a freeze
        nxt(); rst_n = 1'b0; settle();
        nxt(); rst_n = 1'b1; settle();
        nxt(); mem_req = 1'b1; settle();
        nxt(); mem_req = 1'b1; settle();
        nxt(); mem_req = 1'b1; rst_n = 1'b0; settle();
        check("rst_frz_memwb_flush", int'(a_memwb_flush), 1);
        check("rst_frz_ifid_flush", int'(a_ifid_flush), 1);
        nxt(); rst_n = 1'b1; settle();
        check("post_rst_halted", int'(a_halted), 0);
        check("post_rst_pc_en", int'(a_pc_en), 1);
        check("post_rst_wait", int'(a_wait), 0);

        nxt(); settle();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
